// File: rtl/tdm_pkg.sv
// Shared constants and the round-robin search helper for the 8x1 TDM multiplexer.
package tdm_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan from ptr upward with wrap; iterating from the farthest offset down lets the nearest request win.
  function automatic pick_t rr_pick(input logic [N_CH-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] k;
    res.found = 1'b0;
    res.idx   = {SEL_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      k = ptr + i[SEL_W-1:0];
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end else begin
        res.found = res.found;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter; the pointer jumps just past the last granted channel.
module rr_arbiter_8
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [SEL_W-1:0] ptr_r;
  pick_t            pick_s;

  assign pick_s    = rr_pick(req, ptr_r);
  assign grant_idx = pick_s.idx;
  assign grant_vld = pick_s.found;

  // Priority pointer moves only when a grant is actually consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if (advance) begin
      ptr_r <= grant_idx + 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/tdm_mux_8x1.sv
// Eight producers merged onto one valid/ready stream; each word is tagged with its source channel.
module tdm_mux_8x1
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel
);

  logic [SEL_W-1:0]  grant_idx_s;
  logic              grant_vld_s;
  logic              load_s;
  logic              xfer_s;
  logic [DATA_W-1:0] word_s;

  // Accepting is blocked while reset is held so no producer sees a phantom handshake.
  assign load_s = !out_valid || out_ready;
  assign xfer_s = load_s && grant_vld_s && !rst;
  assign word_s = in_data[int'(grant_idx_s)*DATA_W +: DATA_W];

  rr_arbiter_8 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // One-hot accept for the granted channel only.
  always_comb begin
    in_ready = {N_CH{1'b0}};
    if (xfer_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = {N_CH{1'b0}};
    end
  end

  // Output stage: refill on transfer, empty on drain with no refill, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_sel   <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= word_s;
      out_sel   <= grant_idx_s;
    end else if (load_s) begin
      out_valid <= 1'b0;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end
  end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Scoreboard bench for tdm_mux_8x1: directed stimulus pushes expected words, a monitor pops on handshake.
module tb_tdm_mux_8x1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_valid = 8'h00;
  logic [63:0] in_data = 64'h0;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb_q[$];

  tdm_mux_8x1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; exp_rdy is the hand-derived accept vector, pushed to the scoreboard when nonzero.
  task automatic drive(input logic [7:0] v, input logic rdy, input logic [7:0] exp_rdy,
                       input logic [2:0] exp_sel, input logic [7:0] exp_dat, input logic push);
    next_cycle();
    in_valid  = v;
    out_ready = rdy;
    @(negedge clk);
    chk("in_ready", {24'h0, in_ready}, {24'h0, exp_rdy});
    if (push && exp_rdy != 8'h00) sb_q.push_back({exp_sel, exp_dat});
  endtask

  // Monitor: every accepted output word must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [10:0] e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got sel=%0d data=0x%0h, expected none", out_sel, out_data);
      end else begin
        e = sb_q.pop_front();
        if ({out_sel, out_data} !== e) begin
          errors++;
          $display("FAIL out_word: got sel=%0d data=0x%0h, expected sel=%0d data=0x%0h",
                   out_sel, out_data, e[10:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_sel", {29'h0, out_sel}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_in_ready", {24'h0, in_ready}, 32'h0);

    // Release reset and run a full double rotation with every channel valid.
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      if (i == 0) rst = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rot_in_ready", {24'h0, in_ready}, {24'h0, 8'h01 << (i % 8)});
      sb_q.push_back({3'(i % 8), 8'h10 + 8'(i % 8)});
    end
    drive(8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("drain_out_valid", {31'h0, out_valid}, 32'h0);

    // Single channel 2 carrying 0xA5.
    in_data[2*8 +: 8] = 8'hA5;
    drive(8'h04, 1'b1, 8'h04, 3'd2, 8'hA5, 1'b1);
    drive(8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0);
    in_data[2*8 +: 8] = 8'h12;

    // Backpressure with channel 3 held in the output register.
    drive(8'hFF, 1'b1, 8'h08, 3'd3, 8'h13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_in_ready", {24'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out_sel", {29'h0, out_sel}, 32'h3);
      chk("bp_out_data", {24'h0, out_data}, 32'h13);
    end
    drive(8'hFF, 1'b1, 8'h10, 3'd4, 8'h14, 1'b1);
    drive(8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0);

    // Wrap and skip: bring ptr to 6, then only channels 0 and 1 request.
    drive(8'h20, 1'b1, 8'h20, 3'd5, 8'h15, 1'b1);
    drive(8'h03, 1'b1, 8'h01, 3'd0, 8'h10, 1'b1);
    drive(8'h03, 1'b1, 8'h02, 3'd1, 8'h11, 1'b1);
    drive(8'h0C, 1'b1, 8'h04, 3'd2, 8'h12, 1'b1);
    drive(8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0);

    // Asynchronous reset while channel 5's word is held; that word is discarded.
    drive(8'h20, 1'b1, 8'h20, 3'd5, 8'h15, 1'b0);
    next_cycle();
    in_valid  = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
    chk("pre_rst_out_sel", {29'h0, out_sel}, 32'h5);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_out_sel", {29'h0, out_sel}, 32'h0);
    chk("async_rst_out_data", {24'h0, out_data}, 32'h0);
    #1 rst = 1'b0;
    drive(8'hFF, 1'b1, 8'h01, 3'd0, 8'h10, 1'b1);
    drive(8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("final_out_valid", {31'h0, out_valid}, 32'h0);
    chk("scoreboard_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
